// File: rtl/io_pkg.sv
// Shared definitions for the time-multiplexed I/O controller.
//   state_t     : scan FSM states
//   sel_width   : mux select width for a given slot count
//   addr_width  : CPU register address width for a given port/slot count
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SETTLE,
    SAMPLE
  } state_t;

  function automatic int sel_width(input int slots);
    return $clog2(slots);
  endfunction

  function automatic int addr_width(input int ports, input int slots);
    return $clog2(ports * slots);
  endfunction

  // Widths at the default configuration (2 ports x 8 slots).
  localparam int DEF_SEL_W  = sel_width(8);
  localparam int DEF_ADDR_W = addr_width(2, 8);

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input vector
//   q   : synchronised output, two clk edges behind d
module io_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_mux_port.sv
// Time-multiplexed I/O controller. NUM_PORTS byte ports each fan out to
// SLOTS external devices via a shared external mux; the scan FSM walks the
// slots, drives output slots and samples input slots into shadow registers.
// The CPU only ever touches the shadow registers.
//   clk, rst          : clock, asynchronous active-high reset
//   io_addr           : {port, slot} register address
//   io_wdata          : write data
//   io_we / io_re     : write / read strobes
//   io_cfg            : access the direction bit instead of the data register
//   io_rdata/io_ready : read data and one-cycle acknowledge
//   scan_en           : enables scanning
//   mux_sel           : external mux select, shared by all ports
//   pad_out / pad_oe  : pad drive values and per-port enables (tri-state at chip top)
//   pad_in            : pad inputs, asynchronous to clk
//   scan_done         : one-cycle pulse after each full sweep
module io_mux_port
  import io_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_PORTS  = 2,
  parameter int SLOTS      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [addr_width(NUM_PORTS, SLOTS)-1:0]   io_addr,
  input  logic [WIDTH-1:0]                          io_wdata,
  input  logic                                      io_we,
  input  logic                                      io_re,
  input  logic                                      io_cfg,
  output logic [WIDTH-1:0]                          io_rdata,
  output logic                                      io_ready,
  input  logic                                      scan_en,
  output logic [sel_width(SLOTS)-1:0]               mux_sel,
  output logic [NUM_PORTS*WIDTH-1:0]                pad_out,
  output logic [NUM_PORTS-1:0]                      pad_oe,
  input  logic [NUM_PORTS*WIDTH-1:0]                pad_in,
  output logic                                      scan_done
);

  localparam int SEL_W  = sel_width(SLOTS);
  localparam int ADDR_W = addr_width(NUM_PORTS, SLOTS);
  localparam int NREG   = NUM_PORTS * SLOTS;
  localparam int CNT_W  = $clog2(SETTLE_CYC + 2) + 1;
  // SETTLE lasts SETTLE_CYC cycles of mux settling plus two synchroniser stages.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC + 1);

  state_t             state, state_next;
  logic [SEL_W-1:0]   slot;
  logic [CNT_W-1:0]   settle_cnt;

  logic [WIDTH-1:0]   out_reg [NREG];
  logic [WIDTH-1:0]   in_reg  [NREG];
  logic [NREG-1:0]    dir;

  logic [NUM_PORTS*WIDTH-1:0] pad_sync;
  logic                       addr_ok;
  logic [WIDTH-1:0]           rd_val;

  // SLOTS is a power of two, so {port, slot} is simply port*SLOTS OR slot.
  function automatic logic [ADDR_W-1:0] reg_idx(input int p, input logic [SEL_W-1:0] s);
    return ADDR_W'(p * SLOTS) | ADDR_W'(s);
  endfunction

  io_sync2 #(.WIDTH(NUM_PORTS * WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_in),
    .q   (pad_sync)
  );

  // The slot counter drives the mux directly; it only advances when leaving
  // SAMPLE, so the select always changes while every pad_oe is low.
  assign mux_sel = slot;

  // Widened compare stays meaningful when NREG fills the whole address space.
  assign addr_ok = ({1'b0, io_addr} < (ADDR_W + 1)'(NREG));

  // ---------------------------------------------------------------- scan FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= '0;
      settle_cnt <= '0;
      scan_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register in
      // this block samples pre-edge values regardless of statement order.
      state      <= state_next;
      settle_cnt <= (state == SETTLE) ? settle_cnt + CNT_W'(1) : '0;
      if (state == SAMPLE) slot <= slot + SEL_W'(1);
      scan_done  <= (state == SAMPLE) && (slot == SEL_W'(SLOTS - 1));
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_next = state;
    pad_oe     = '0;
    pad_out    = '0;
    case (state)
      IDLE:    if (scan_en) state_next = GAP;
      GAP:     state_next = SETTLE;
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
        // Live view of the shadow registers: CPU writes reach the pads next cycle.
        for (int p = 0; p < NUM_PORTS; p++) begin
          pad_oe[p]                 = dir[reg_idx(p, slot)];
          pad_out[p*WIDTH +: WIDTH] = out_reg[reg_idx(p, slot)];
        end
      end
      SAMPLE:  state_next = scan_en ? GAP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ----------------------------------------------------------- register file
  always_comb begin
    rd_val = '0;
    if (addr_ok) begin
      if (io_cfg)            rd_val = {{(WIDTH-1){1'b0}}, dir[io_addr]};
      else if (dir[io_addr]) rd_val = out_reg[io_addr];
      else                   rd_val = in_reg[io_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow arrays are reset explicitly because every slot must
      // come up as a zero-valued input; this keeps them in flops, not RAM.
      for (int i = 0; i < NREG; i++) begin
        out_reg[i] <= '0;
        in_reg[i]  <= '0;
      end
      dir      <= '0;
      io_ready <= 1'b0;
      io_rdata <= '0;
    end else begin
      io_ready <= io_we | io_re;
      // rd_val is the pre-edge value, so a combined write+read returns old data.
      if (io_re) io_rdata <= rd_val;
      if (io_we && addr_ok) begin
        if (io_cfg) dir[io_addr]     <= io_wdata[0];
        else        out_reg[io_addr] <= io_wdata;
      end
      // Output slots are never sampled; dir is checked as it stands at SAMPLE.
      if (state == SAMPLE) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!dir[reg_idx(p, slot)])
            in_reg[reg_idx(p, slot)] <= pad_sync[p*WIDTH +: WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_io_mux_port.sv
// Self-checking bench for io_mux_port at default parameters. CPU reads push
// their expected data into a scoreboard; a monitor pops on every io_ready.
// The external devices are modelled as a table indexed by {port, mux_sel}.
module tb_io_mux_port;

  logic        clk;
  logic        rst;
  logic [3:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we, io_re, io_cfg;
  logic [7:0]  io_rdata;
  logic        io_ready;
  logic        scan_en;
  logic [2:0]  mux_sel;
  logic [15:0] pad_out;
  logic [1:0]  pad_oe;
  logic [15:0] pad_in;
  logic        scan_done;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic       has_data;
    logic [7:0] data;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] dev_val [16];
  logic [7:0] out_m   [16];
  logic       dir_m   [16];
  logic [7:0] old7;

  io_mux_port dut (
    .clk       (clk),
    .rst       (rst),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_re     (io_re),
    .io_cfg    (io_cfg),
    .io_rdata  (io_rdata),
    .io_ready  (io_ready),
    .scan_en   (scan_en),
    .mux_sel   (mux_sel),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .pad_in    (pad_in),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External mux: each port presents the device selected by mux_sel.
  assign pad_in = {dev_val[{1'b1, mux_sel}], dev_val[{1'b0, mux_sel}]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && io_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.has_data) check(e.tag, {24'd0, io_rdata}, {24'd0, e.data});
      end
    end
  end

  // One CPU access, issued at a negedge and held for one clock.
  task automatic cpu(input logic we, input logic re, input logic cfg,
                     input logic [3:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp, input string tag);
    exp_t e;
    io_we = we; io_re = re; io_cfg = cfg; io_addr = addr; io_wdata = wdata;
    e.has_data = re; e.data = exp; e.tag = tag;
    sb.push_back(e);
    if (we) begin
      if (cfg) dir_m[addr] = wdata[0];
      else     out_m[addr] = wdata;
    end
    @(negedge clk);
    io_we = 1'b0; io_re = 1'b0; io_cfg = 1'b0;
  endtask

  // Checks one slot: GAP (ph 0), SETTLE (ph 1..4), SAMPLE (ph 5).
  task automatic run_slot(input int s, input logic done, input logic drop);
    for (int ph = 0; ph < 6; ph++) begin
      logic [1:0]  oe_e;
      logic [15:0] po_e;
      logic        act;
      act  = (ph >= 1) && (ph <= 4);
      oe_e = act ? {dir_m[8+s], dir_m[s]} : 2'b00;
      po_e = act ? {out_m[8+s], out_m[s]} : 16'h0000;
      check($sformatf("slot%0d_ph%0d", s, ph),
            {10'd0, scan_done, mux_sel, pad_oe, pad_out},
            {10'd0, (done && ph == 0), 3'(s), oe_e, po_e});
      if (drop && ph == 2) scan_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input logic [2:0] sel);
    check(tag, {10'd0, scan_done, mux_sel, pad_oe, pad_out}, {10'd0, 1'b0, sel, 2'b00, 16'h0000});
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0;
    io_we = 1'b0; io_re = 1'b0; io_cfg = 1'b0; io_addr = '0; io_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      dev_val[i] = 8'(i * 29 + 7);
      out_m[i]   = 8'h00;
      dir_m[i]   = 1'b0;
    end
    dev_val[5] = 8'h3C;

    repeat (2) @(negedge clk);
    check("reset_outputs", {7'd0, io_ready, io_rdata, scan_done, mux_sel, pad_oe, pad_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    cpu(1'b0, 1'b1, 1'b0, 4'd5,  8'h00, 8'h00, "rd_in5_reset");
    cpu(1'b1, 1'b0, 1'b1, 4'd10, 8'h01, 8'h00, "wr_dir10");
    cpu(1'b1, 1'b0, 1'b0, 4'd10, 8'hA5, 8'h00, "wr_out10");
    cpu(1'b1, 1'b0, 1'b1, 4'd3,  8'h01, 8'h00, "wr_dir3");
    cpu(1'b1, 1'b0, 1'b0, 4'd3,  8'h5A, 8'h00, "wr_out3");
    cpu(1'b0, 1'b1, 1'b1, 4'd10, 8'h00, 8'h01, "rd_dir10");
    cpu(1'b0, 1'b1, 1'b0, 4'd10, 8'h00, 8'hA5, "rd_out10");

    // Two full sweeps: mux_sel 0..7 twice, scan_done once at the 48-cycle wrap.
    scan_en = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 8; s++) run_slot(s, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) run_slot(s, s == 0, 1'b0);

    // Third sweep with new device values, stopped during slot 6.
    old7 = dev_val[7];
    dev_val[6] = 8'hC6; dev_val[7] = 8'hD7; dev_val[14] = 8'hE4;
    for (int s = 0; s < 6; s++) run_slot(s, s == 0, 1'b0);
    run_slot(6, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_idle($sformatf("idle_after_drop%0d", i), 3'd7);
      @(negedge clk);
    end

    cpu(1'b0, 1'b1, 1'b0, 4'd5,  8'h00, 8'h3C,       "rd_in5");
    cpu(1'b0, 1'b1, 1'b0, 4'd6,  8'h00, 8'hC6,       "rd_in6");
    cpu(1'b0, 1'b1, 1'b0, 4'd7,  8'h00, old7,        "rd_in7_unsampled");
    cpu(1'b0, 1'b1, 1'b0, 4'd14, 8'h00, 8'hE4,       "rd_in14");
    cpu(1'b0, 1'b1, 1'b0, 4'd13, 8'h00, dev_val[13], "rd_in13");
    cpu(1'b0, 1'b1, 1'b0, 4'd2,  8'h00, dev_val[2],  "rd_in2");
    cpu(1'b0, 1'b1, 1'b0, 4'd3,  8'h00, 8'h5A,       "rd_out3");
    cpu(1'b0, 1'b1, 1'b0, 4'd10, 8'h00, 8'hA5,       "rd_out10_b");
    cpu(1'b1, 1'b1, 1'b0, 4'd10, 8'h11, 8'hA5,       "wr_rd_same_cycle");
    cpu(1'b0, 1'b1, 1'b0, 4'd10, 8'h00, 8'h11,       "rd_out10_new");

    // Resume continues at slot 7, then wraps with a scan_done pulse.
    scan_en = 1'b1;
    @(negedge clk);
    run_slot(7, 1'b0, 1'b0);
    run_slot(0, 1'b1, 1'b0);
    run_slot(1, 1'b0, 1'b0);
    run_slot(2, 1'b0, 1'b0);

    // Reset hits during SETTLE of slot 3 while dir[3]=1 drives port 0.
    check("slot3_gap", {10'd0, scan_done, mux_sel, pad_oe, pad_out}, {10'd0, 1'b0, 3'd3, 2'b00, 16'h0000});
    @(negedge clk);
    check("slot3_settle", {10'd0, scan_done, mux_sel, pad_oe, pad_out}, {10'd0, 1'b0, 3'd3, 2'b01, 16'h005A});
    #2 rst = 1'b1; scan_en = 1'b0;
    #1 check("reset_mid_settle", {7'd0, io_ready, io_rdata, scan_done, mux_sel, pad_oe, pad_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dir_m[i] = 1'b0;
      out_m[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle_after_reset%0d", i), 3'd0);
    end
    cpu(1'b0, 1'b1, 1'b1, 4'd3,  8'h00, 8'h00, "rd_dir3_after_reset");
    cpu(1'b0, 1'b1, 1'b0, 4'd10, 8'h00, 8'h00, "rd_10_after_reset");

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_mux_port.md
Name: io_mux_port

Overview:
- Parametrised time-multiplexed I/O controller.
- Maps NUM_PORTS physical byte ports, each fanned out to SLOTS external devices through an external mux, onto NUM_PORTS*SLOTS CPU-addressable I/O registers.
- A scan FSM cycles mux_sel through all slots, drives output slots and samples input slots into shadow registers. The CPU reads and writes only the shadow registers, through a single-cycle handshake.
- Pad tri-stating is done at chip top from pad_out/pad_oe. No inout inside this block.

Parameters:
- WIDTH, 8, bits per port and per I/O register.
- NUM_PORTS, 2, physical ports.
- SLOTS, 8, mux slots per port; must be a power of 2, at least 2.
- SETTLE_CYC, 2, cycles mux_sel is held stable before sampling; must be at least 1.
- Derived, not overridable: SEL_W = clog2(SLOTS); ADDR_W = clog2(NUM_PORTS*SLOTS), which is 4 at the defaults.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_addr  in  ADDR_W  register address; upper bits select the port, lower SEL_W bits select the slot.
- io_wdata  in  WIDTH  write data.
- io_we  in  1  write strobe.
- io_re  in  1  read strobe.
- io_cfg  in  1  when 1, the access targets the direction bit instead of the data register.
- io_rdata  out  WIDTH  read data; valid when io_ready=1.
- io_ready  out  1  one-cycle acknowledge of a read or write.
- scan_en  in  1  enables the scan FSM.
- mux_sel  out  SEL_W  external mux select, shared by all ports.
- pad_out  out  NUM_PORTS*WIDTH  pad drive values.
- pad_oe  out  NUM_PORTS  per-port output enable.
- pad_in  in  NUM_PORTS*WIDTH  pad input values; asynchronous to clk.
- scan_done  out  1  one-cycle pulse at the end of each full sweep.

Behaviour:
- Reset values, applied asynchronously:
  - all out_reg, in_reg and dir bits = 0, so every slot is an input;
  - io_rdata=0, io_ready=0, mux_sel=0, pad_out=0, pad_oe=0, scan_done=0;
  - FSM in IDLE, slot counter 0.
- Reset asserted mid-sweep aborts the sweep immediately, with pad_oe=0 in the same cycle.
- Synchroniser: pad_in passes through a 2-flop synchroniser per bit before sampling. SETTLE_CYC counts from the mux_sel change, and sampling uses the synchronised value 2 cycles later.
- CPU write (io_we=1 at edge N):
  - io_cfg=0: out_reg[addr] <= io_wdata.
  - io_cfg=1: dir[addr] <= io_wdata[0].
  - io_ready=1 in cycle N+1.
- CPU read (io_re=1 at edge N): io_ready=1 and io_rdata valid in cycle N+1.
  - io_cfg=1: returns {0..., dir[addr]}.
  - io_cfg=0 and dir=1: returns out_reg[addr].
  - io_cfg=0 and dir=0: returns in_reg[addr].
- Simultaneous io_we and io_re: the write is performed; io_rdata returns the pre-write value; only one io_ready pulse is produced.
- Address beyond NUM_PORTS*SLOTS-1 (only possible when NUM_PORTS is not a power of 2): writes are ignored, reads return 0, and io_ready is still pulsed.
- Back-to-back accesses are legal every cycle.
- FSM states: IDLE, GAP, SETTLE, SAMPLE.
  - IDLE: pad_oe=0. Leave to GAP when scan_en=1.
  - GAP, one cycle: pad_oe=0; mux_sel <= slot. This is the bus-turnaround gap that prevents contention between devices.
  - SETTLE, for SETTLE_CYC+2 cycles:
    - per port p, pad_oe[p] = dir[p*SLOTS+slot];
    - pad_out[p] = out_reg[p*SLOTS+slot], tracking live, so a write during SETTLE reaches the pads the cycle after the write edge.
  - SAMPLE, one cycle:
    - for each port with dir=0, in_reg[p*SLOTS+slot] <= synchronised pad_in[p]; output slots are not sampled.
    - Then slot <= slot+1, wrapping to 0 after SLOTS-1; at the wrap, scan_done pulses in the following cycle.
    - If scan_en=0, go to IDLE, else go to GAP.
- scan_en deasserted mid-slot: the current slot completes through SAMPLE, then the FSM parks in IDLE. The slot counter is retained, and resuming continues at the next slot.
- Direction change mid-SETTLE on the active slot: pad_oe follows the next cycle. That slot's sample is suppressed if dir=1 at SAMPLE.
- Sweep length: SLOTS*(SETTLE_CYC+4) cycles, which is 48 at the defaults.

Decomposition:
- Package io_pkg: FSM state enum (IDLE, GAP, SETTLE, SAMPLE); localparams SEL_W and ADDR_W as functions of the parameters.
- Sub-module io_sync2: 2-flop synchroniser, parametrised width, asynchronous reset to 0. Instantiated once across NUM_PORTS*WIDTH bits.
- Register file and FSM stay in io_mux_port.

Test Plan:
- Reset: rst=1 mid-SETTLE with dir[3]=1 -> pad_oe=0 and mux_sel=0 in the same cycle, io_rdata=0; after release with scan_en=0 the FSM stays IDLE.
- Output drive:
  - stimulus: write cfg addr 10 <= 1, data addr 10 <= 0xA5, scan_en=1;
  - required: when mux_sel=2, pad_oe[1]=1 and pad_out[15:8]=0xA5 throughout SETTLE, with pad_oe[1]=0 in GAP.
- Input sample:
  - stimulus: pad_in[7:0]=0x3C held during slot 5;
  - required: after that slot's SAMPLE, a read of addr 5 returns 0x3C with 1-cycle latency; a read of output addr 10 returns 0xA5.
- Simultaneous access: io_we and io_re to addr 10 (old value 0xA5, new value 0x11) -> io_rdata=0xA5 with a single io_ready; the next read returns 0x11.
- Wrap and done:
  - a full sweep produces one scan_done pulse 48 cycles apart;
  - mux_sel sequence is 0..7,0;
  - scan_en dropped during slot 6 -> slot 6 is sampled, IDLE is entered, and resuming starts at slot 7.
- Turnaround: at every slot boundary, pad_oe=0 in GAP; pad_oe is never 1 in the cycle in which mux_sel changes.
